framebuffer_write_arbiter: RTL and testbench

- Owns the single write port of the 12-bit framebuffer dual-port RAM.
- Shares that port between two requesters:
  - the external pixel stream, strobed by an asynchronous pixel_clock;
  - an internal fill engine that paints the whole frame with one colour.
- Also maintains the stream write pointer: wrap at end of frame, host-settable position.
- Sits between the bus-side pixel input and the RAM; the read side is untouched.

---
 rtl/fb_pkg.sv | 13 +
 rtl/edge_synchronizer.sv | 26 ++
 rtl/framebuffer_write_arbiter.sv | 118 +++++++++++
 tb/tb_framebuffer_write_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel/address widths and fill-engine state encoding.
package fb_pkg;
    localparam int FRAME_WIDTH      = 640;
    localparam int FRAME_HEIGHT     = 480;
    localparam int FRAME_PIXELS     = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int PIXEL_WIDTH      = 12;
    localparam int FB_ADDRESS_WIDTH = 22;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_e;
endpackage

// File: rtl/edge_synchronizer.sv
// Two-flop synchroniser plus history flop; rise_o pulses for one cycle per
// synchronised rising edge of an asynchronous strobe.
module edge_synchronizer (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);
    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~hist_q;
endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Owns the framebuffer RAM write port: stream pixels (priority) and a full-frame
// fill engine share it, one write per cycle; also keeps the stream write pointer.
module framebuffer_write_arbiter
    import fb_pkg::*;
#(
    parameter int FRAME_PIXELS  = fb_pkg::FRAME_PIXELS,
    parameter int ADDRESS_WIDTH = fb_pkg::FB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = fb_pkg::PIXEL_WIDTH
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     pixel_clock,
    input  logic [DATA_WIDTH-1:0]    pixel_data,
    input  logic                     set_pointer,
    input  logic [ADDRESS_WIDTH-1:0] pointer_value,
    input  logic                     fill_start,
    input  logic [DATA_WIDTH-1:0]    fill_colour,
    input  logic                     fill_abort,
    output logic [ADDRESS_WIDTH-1:0] ram_write_address,
    output logic [DATA_WIDTH-1:0]    ram_write_data,
    output logic                     ram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] stream_pointer,
    output logic                     frame_wrap,
    output logic                     fill_busy,
    output logic                     fill_done
);
    localparam logic [ADDRESS_WIDTH-1:0] FRAME_LIMIT = ADDRESS_WIDTH'(FRAME_PIXELS);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR   = ADDRESS_WIDTH'(FRAME_PIXELS - 1);

    logic                     pix_rise;
    logic                     pend_q;
    logic [DATA_WIDTH-1:0]    hold_q;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    fill_state_e              state_q;
    logic [ADDRESS_WIDTH-1:0] fill_addr_q;
    logic [DATA_WIDTH-1:0]    colour_q;
    logic                     done_q;
    logic                     stream_wr;
    logic                     fill_wr;
    logic                     ptr_at_last;

    edge_synchronizer u_pixel_sync (
        .clk_i   (system_clock),
        .rst_i   (reset),
        .async_i (pixel_clock),
        .rise_o  (pix_rise)
    );

    // The held pixel always wins the port; the fill simply stalls that cycle.
    assign stream_wr   = pend_q;
    assign fill_wr     = (state_q == FILL_RUN) && !stream_wr && !fill_abort;
    assign ptr_at_last = (ptr_q == LAST_ADDR);

    assign ram_write_enable  = stream_wr | fill_wr;
    assign ram_write_address = stream_wr ? ptr_q  : (fill_wr ? fill_addr_q : '0);
    assign ram_write_data    = stream_wr ? hold_q : (fill_wr ? colour_q    : '0);
    assign frame_wrap        = stream_wr && ptr_at_last && !set_pointer;
    assign stream_pointer    = ptr_q;
    assign fill_busy         = (state_q == FILL_RUN);
    assign fill_done         = done_q;

    always_comb begin
        ptr_d = ptr_q;
        if (set_pointer) begin
            ptr_d = (pointer_value >= FRAME_LIMIT) ? '0 : pointer_value;
        end else if (stream_wr) begin
            ptr_d = ptr_at_last ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            hold_q <= '0;
            ptr_q  <= '0;
        end else begin
            pend_q <= pix_rise;
            if (pix_rise) begin
                hold_q <= pixel_data;
            end
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state_q     <= FILL_IDLE;
            fill_addr_q <= '0;
            colour_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                FILL_IDLE: begin
                    if (fill_start) begin
                        state_q     <= FILL_RUN;
                        fill_addr_q <= '0;
                        colour_q    <= fill_colour;
                    end
                end
                FILL_RUN: begin
                    if (fill_abort) begin
                        state_q <= FILL_IDLE;
                        done_q  <= 1'b1;
                    end else if (fill_wr) begin
                        if (fill_addr_q == LAST_ADDR) begin
                            state_q <= FILL_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            fill_addr_q <= fill_addr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= FILL_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Randomised scoreboard bench: stimulus queues expected stream/fill writes, a
// negedge monitor compares every RAM write and status output against them.
module tb_framebuffer_write_arbiter;
    localparam int FP = 100;
    localparam int AW = 22;
    localparam int DW = 12;

    logic          system_clock = 1'b0;
    logic          reset = 1'b1;
    logic          pixel_clock = 1'b0;
    logic [DW-1:0] pixel_data = '0;
    logic          set_pointer = 1'b0;
    logic [AW-1:0] pointer_value = '0;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_colour = '0;
    logic          fill_abort = 1'b0;
    logic [AW-1:0] ram_write_address;
    logic [DW-1:0] ram_write_data;
    logic          ram_write_enable;
    logic [AW-1:0] stream_pointer;
    logic          frame_wrap;
    logic          fill_busy;
    logic          fill_done;

    framebuffer_write_arbiter #(.FRAME_PIXELS(FP), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .system_clock(system_clock), .reset(reset), .pixel_clock(pixel_clock),
        .pixel_data(pixel_data), .set_pointer(set_pointer), .pointer_value(pointer_value),
        .fill_start(fill_start), .fill_colour(fill_colour), .fill_abort(fill_abort),
        .ram_write_address(ram_write_address), .ram_write_data(ram_write_data),
        .ram_write_enable(ram_write_enable), .stream_pointer(stream_pointer),
        .frame_wrap(frame_wrap), .fill_busy(fill_busy), .fill_done(fill_done)
    );

    always #5 system_clock = ~system_clock;

    int cyc = 0;
    always @(posedge system_clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: pending stream pixels with the cycle their write is due,
    // remaining fill addresses, the expected stream pointer and fill status.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } sent_t;
    sent_t         sq[$];
    int            fq[$];
    int            mp = 0;
    bit            mbusy = 0;
    logic [DW-1:0] mcolour = '0;
    int            done_due = -1;

    always @(negedge system_clock) begin
        bit stream_now, fill_now, busy_at_start, exp_wrap;
        int newp;
        if (reset) begin
            sq.delete();
            fq.delete();
            mp = 0;
            mbusy = 0;
            done_due = -1;
        end else begin
            if (sq.size() > 0 && sq[0].due < cyc) begin
                check("stream_write_missing", 64'(sq[0].due), 64'(cyc));
                void'(sq.pop_front());
            end
            stream_now    = (sq.size() > 0) && (sq[0].due == cyc);
            busy_at_start = mbusy;
            fill_now      = mbusy && !stream_now && !fill_abort;
            exp_wrap      = stream_now && (mp == FP - 1) && !set_pointer;
            newp          = (int'(pointer_value) >= FP) ? 0 : int'(pointer_value);

            check("fill_busy", 64'(fill_busy), 64'(mbusy));
            check("fill_done", 64'(fill_done), 64'(cyc == done_due));
            check("stream_pointer", 64'(stream_pointer), 64'(mp));
            check("frame_wrap", 64'(frame_wrap), 64'(exp_wrap));
            check("write_enable", 64'(ram_write_enable), 64'(stream_now || fill_now));

            if (stream_now) begin
                check("stream_addr", 64'(ram_write_address), 64'(mp));
                check("stream_data", 64'(ram_write_data), 64'(sq[0].data));
                void'(sq.pop_front());
                mp = set_pointer ? newp : ((mp == FP - 1) ? 0 : mp + 1);
            end else begin
                if (set_pointer) mp = newp;
                if (fill_now) begin
                    check("fill_addr", 64'(ram_write_address), 64'(fq[0]));
                    check("fill_data", 64'(ram_write_data), 64'(mcolour));
                    void'(fq.pop_front());
                    if (fq.size() == 0) begin
                        mbusy = 0;
                        done_due = cyc + 1;
                    end
                end else if (!ram_write_enable) begin
                    check("idle_addr_zero", 64'(ram_write_address), 64'd0);
                    check("idle_data_zero", 64'(ram_write_data), 64'd0);
                end
            end

            if (busy_at_start && mbusy && fill_abort) begin
                mbusy = 0;
                fq.delete();
                done_due = cyc + 1;
            end
            if (!busy_at_start && fill_start) begin
                mbusy = 1;
                mcolour = fill_colour;
                fq.delete();
                for (int a = 0; a < FP; a++) fq.push_back(a);
            end
        end
    end

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    // Rise held 2 cycles, low at least 2: period >= 4 system cycles.
    task automatic send_pixel(input logic [DW-1:0] d);
        sent_t s;
        tick();
        pixel_data  = d;
        pixel_clock = 1'b1;
        s.data = d;
        s.due  = cyc + 3;
        sq.push_back(s);
        tick();
        tick();
        pixel_clock = 1'b0;
        repeat (1 + $urandom_range(0, 2)) tick();
    endtask

    task automatic pulse_start(input logic [DW-1:0] c, input bit with_abort);
        fill_start  = 1'b1;
        fill_colour = c;
        fill_abort  = with_abort;
        tick();
        fill_start = 1'b0;
        fill_abort = 1'b0;
    endtask

    task automatic pulse_set(input int v);
        set_pointer   = 1'b1;
        pointer_value = AW'(v);
        tick();
        set_pointer = 1'b0;
    endtask

    task automatic pulse_abort();
        fill_abort = 1'b1;
        tick();
        fill_abort = 1'b0;
    endtask

    task automatic wait_fill_idle(input int budget);
        int n = 0;
        while (fill_busy && n < budget) begin
            tick();
            n++;
        end
        check("fill_idle_timeout", 64'(fill_busy), 64'd0);
        repeat (4) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 64'(ram_write_enable), 64'd0);
        check({tag, "_addr"}, 64'(ram_write_address), 64'd0);
        check({tag, "_data"}, 64'(ram_write_data), 64'd0);
        check({tag, "_ptr"}, 64'(stream_pointer), 64'd0);
        check({tag, "_wrap"}, 64'(frame_wrap), 64'd0);
        check({tag, "_busy"}, 64'(fill_busy), 64'd0);
        check({tag, "_done"}, 64'(fill_done), 64'd0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        repeat (3) tick();
        reset = 1'b0;
        tick();

        send_pixel(12'hF00);
        send_pixel(12'h0F0);
        send_pixel(12'h00F);
        repeat (3) tick();
        check("ptr_after_three", 64'(stream_pointer), 64'd3);

        pulse_set(FP - 1);
        send_pixel(12'hAAA);
        send_pixel(12'h555);
        repeat (3) tick();
        check("ptr_after_wrap", 64'(stream_pointer), 64'd1);

        pulse_start(12'h123, 1'b0);
        wait_fill_idle(4 * FP);
        check("fill_queue_drained", 64'(fq.size()), 64'd0);

        pulse_start(12'h123, 1'b1);
        fork
            wait_fill_idle(8 * FP);
            repeat (6) send_pixel(DW'($urandom));
        join
        check("fill_queue_drained2", 64'(fq.size()), 64'd0);

        pulse_start(12'h3C3, 1'b0);
        repeat (50) tick();
        pulse_abort();
        repeat (3) tick();
        check("busy_after_abort", 64'(fill_busy), 64'd0);
        pulse_start(12'h7E7, 1'b0);
        wait_fill_idle(4 * FP);

        pulse_abort();
        repeat (2) tick();

        fork
            repeat (30) send_pixel(DW'($urandom));
            repeat (70) begin
                int r;
                repeat ($urandom_range(1, 6)) tick();
                r = $urandom_range(0, 9);
                if (r < 3)       pulse_set($urandom_range(0, FP + 5));
                else if (r < 6)  pulse_start(DW'($urandom), 1'b0);
                else if (r == 6) pulse_start(DW'($urandom), 1'b1);
                else if (r < 9)  pulse_abort();
            end
        join
        wait_fill_idle(8 * FP);

        pulse_start(12'h456, 1'b0);
        repeat (20) tick();
        pixel_data  = 12'hBEE;
        pixel_clock = 1'b1;
        begin
            sent_t s;
            s.data = 12'hBEE;
            s.due  = cyc + 3;
            sq.push_back(s);
        end
        tick();
        tick();
        pixel_clock = 1'b0;
        tick();
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("post_reset_queue", 64'(sq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
